// File: rtl/uart_tx.sv
// 8N1 UART transmitter with byte FIFO; LSB-first, one start and one stop bit.
// Back-to-back frames when the FIFO holds data at the end of a stop bit.
module uart_tx #(
    parameter int BAUD_DIV   = 2603,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] data_in,
    input  logic       WR,
    output logic       TX,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       tx_done
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int CW    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    localparam logic [CW-1:0]         CNT_MAX  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
    localparam logic [DEPTH_LOG2:0]   OCC_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   OCC_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shreg_q, shreg_d;
    logic                  tx_q, tx_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   occ_q, occ_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic [7:0]            mem_q [DEPTH];

    logic bit_end;
    logic push;
    logic pop;

    assign bit_end = (cnt_q == CNT_MAX);
    // A full FIFO refuses writes even when a pop frees a slot that cycle.
    assign push    = WR && !full_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = bit_end ? '0 : cnt_q + CNT_ONE;
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!empty_q) begin
                    pop     = 1'b1;
                    shreg_d = mem_q[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!empty_q) begin
                        pop     = 1'b1;
                        shreg_d = mem_q[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the next state so TX is a clean flop output.
        tx_d = 1'b1;
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = shreg_d[bit_idx_d];
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        occ_d    = occ_q;
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
        full_d  = (occ_d == OCC_FULL);
        empty_d = (occ_d == '0);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign TX      = tx_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign busy    = (state_q != IDLE);
    assign tx_done = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: records the line each cycle and compares it with
// frames built arithmetically from the bytes expected on the wire.
module tb_uart_tx;

    localparam int BD = 4;
    localparam int DL = 2;
    localparam int FL = 10 * BD;

    logic       Clk     = 1'b0;
    logic       Reset   = 1'b1;
    logic       WR      = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       TX;
    logic       full;
    logic       empty;
    logic       busy;
    logic       tx_done;

    int checks = 0;
    int errors = 0;

    logic       rec_on = 1'b0;
    logic       txq[$];
    logic       dq[$];
    logic [7:0] expq[$];

    uart_tx #(
        .BAUD_DIV  (BD),
        .DEPTH_LOG2(DL)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .data_in(data_in),
        .WR     (WR),
        .TX     (TX),
        .full   (full),
        .empty  (empty),
        .busy   (busy),
        .tx_done(tx_done)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (rec_on) begin
            txq.push_back(TX);
            dq.push_back(tx_done);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic write(input logic [7:0] b, input bit keep);
        data_in = b;
        WR      = 1'b1;
        @(negedge Clk);
        WR      = 1'b0;
        if (keep) expq.push_back(b);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(busy === 1'b0 && empty === 1'b1) && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        check({tag, " idle timeout"}, 64'(n < 1000), 64'd1);
        repeat (3) @(negedge Clk);
    endtask

    task automatic check_line(input string tag);
        int pos = 0;
        int gap;
        int lows = 0;
        int strays = 0;
        logic [FL-1:0] got, want, gd, wd;
        logic [9:0] fr;
        for (int f = 0; f < expq.size(); f++) begin
            gap = 0;
            while (pos < txq.size() && txq[pos] === 1'b1) begin
                strays += (dq[pos] !== 1'b0) ? 1 : 0;
                pos++;
                gap++;
            end
            if (f > 0) check({tag, " gap"}, 64'(gap), 64'd0);
            fr = {1'b1, expq[f], 1'b0};
            for (int i = 0; i < FL; i++) begin
                want[i] = fr[i / BD];
                wd[i]   = (i == FL - 1);
                got[i]  = (pos + i < txq.size()) ? txq[pos + i] : 1'bx;
                gd[i]   = (pos + i < dq.size()) ? dq[pos + i] : 1'bx;
            end
            check({tag, " line"}, 64'(got), 64'(want));
            check({tag, " done"}, 64'(gd), 64'(wd));
            pos += FL;
        end
        for (; pos < txq.size(); pos++) begin
            lows   += (txq[pos] !== 1'b1) ? 1 : 0;
            strays += (dq[pos] !== 1'b0) ? 1 : 0;
        end
        check({tag, " extra frames"}, 64'(lows), 64'd0);
        check({tag, " stray done"}, 64'(strays), 64'd0);
        expq.delete();
        txq.delete();
        dq.delete();
    endtask

    initial begin
        logic [7:0] r;
        int n;

        // Reset values
        repeat (2) @(negedge Clk);
        check("rst TX", 64'(TX), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst done", 64'(tx_done), 64'd0);
        check("rst full", 64'(full), 64'd0);
        check("rst empty", 64'(empty), 64'd1);

        // Single frame and first-edge latency
        rec_on = 1'b1;
        @(negedge Clk);
        write(8'h55, 1'b1);
        check("lat TX at N", 64'(TX), 64'd1);
        check("lat empty at N", 64'(empty), 64'd0);
        @(posedge Clk);
        #1;
        check("lat TX at N+1", 64'(TX), 64'd0);
        check("lat busy at N+1", 64'(busy), 64'd1);
        check("lat empty at N+1", 64'(empty), 64'd1);
        @(negedge Clk);
        wait_idle("t1");
        rec_on = 1'b0;
        check_line("t1");

        // Two back-to-back frames
        rec_on = 1'b1;
        @(negedge Clk);
        write(8'hA3, 1'b1);
        write(8'h0F, 1'b1);
        wait_idle("t2");
        rec_on = 1'b0;
        check_line("t2");

        // Overflow while sending
        rec_on = 1'b1;
        @(negedge Clk);
        r = 8'($urandom);
        write(r, 1'b1);
        repeat (6) @(negedge Clk);
        write(8'h11, 1'b1);
        write(8'h22, 1'b1);
        write(8'h33, 1'b1);
        check("t3 not full", 64'(full), 64'd0);
        write(8'h44, 1'b1);
        check("t3 full", 64'(full), 64'd1);
        write(8'h55, 1'b0);
        check("t3 still full", 64'(full), 64'd1);
        wait_idle("t3");
        rec_on = 1'b0;
        check_line("t3");

        // Write while full on the STOP->START pop edge
        rec_on = 1'b1;
        @(negedge Clk);
        write(8'($urandom), 1'b1);
        repeat (2) @(negedge Clk);
        for (int i = 0; i < 4; i++) write(8'($urandom), 1'b1);
        check("t4 full", 64'(full), 64'd1);
        n = 0;
        while (tx_done !== 1'b1 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        check("t4 done timeout", 64'(n < 100), 64'd1);
        data_in = 8'h99;
        WR      = 1'b1;
        @(negedge Clk);
        WR      = 1'b0;
        check("t4 count 3", 64'(full), 64'd0);
        check("t4 not empty", 64'(empty), 64'd0);
        write(8'h77, 1'b1);
        check("t4 refill", 64'(full), 64'd1);
        wait_idle("t4");
        rec_on = 1'b0;
        check_line("t4");

        // Reset during DATA bit 3
        @(negedge Clk);
        write(8'hFF, 1'b0);
        write(8'h12, 1'b0);
        n = 0;
        while (TX !== 1'b0 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check("t5 start timeout", 64'(n < 20), 64'd1);
        repeat (4 + 3 * BD + 1) @(negedge Clk);
        check("t5 mid busy", 64'(busy), 64'd1);
        check("t5 mid empty", 64'(empty), 64'd0);
        Reset = 1'b1;
        #1;
        check("t5 rst TX", 64'(TX), 64'd1);
        check("t5 rst busy", 64'(busy), 64'd0);
        check("t5 rst empty", 64'(empty), 64'd1);
        @(negedge Clk);
        Reset = 1'b0;
        rec_on = 1'b1;
        @(negedge Clk);
        write(8'h81, 1'b1);
        wait_idle("t5");
        rec_on = 1'b0;
        check_line("t5");

        // Fixed and random byte streams
        rec_on = 1'b1;
        @(negedge Clk);
        write(8'h00, 1'b1);
        write(8'hFF, 1'b1);
        write(8'h5A, 1'b1);
        write(8'hA5, 1'b1);
        wait_idle("t6");
        rec_on = 1'b0;
        check_line("t6");
        for (int k = 0; k < 3; k++) begin
            rec_on = 1'b1;
            @(negedge Clk);
            for (int i = 0; i < 4; i++) write(8'($urandom), 1'b1);
            wait_idle("t7");
            rec_on = 1'b0;
            check_line("t7");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
